// File: rtl/encode_pkg.sv
// Shared types and constants for the LZS encode job scheduler.
package encode_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ERST,
    S_RUN,
    S_FIN
  } state_e;

  localparam int ERST_CYCLES = 2;

  typedef logic chan_t;

  function automatic logic [1:0] chan_onehot(input chan_t c);
    return c ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/encode_sched_rr.sv
// Two-way round-robin arbiter: on contention the channel not served last wins.
module encode_sched_rr
  import encode_pkg::*;
(
  input  logic [1:0] req_i,
  input  chan_t      ptr_i,
  output logic [1:0] win_o,
  output logic       vld_o
);

  always_comb begin
    win_o = 2'b00;
    unique case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11:   win_o = ptr_i ? 2'b01 : 2'b10;
      default: win_o = 2'b00;
    endcase
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/encode_sched.sv
// Two-channel job scheduler/sequencer for the shared LZS encode engine.
// Optional RUN watchdog enabled by defining ENCODE_SCHED_TMO_EN.
module encode_sched
  import encode_pkg::*;
#(
  parameter int LZF_WIDTH  = 20,
  parameter int WCNT_WIDTH = 16,
  parameter int TMO_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [LZF_WIDTH-1:0]  len0,
  input  logic [LZF_WIDTH-1:0]  len1,
  input  logic                  abort,
  input  logic                  m_dst_putn,
  input  logic                  m_endn,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic                  done_err,
  output logic [WCNT_WIDTH-1:0] done_words,
  output logic                  eng_sel,
  output logic [LZF_WIDTH-1:0]  eng_cnt,
  output logic                  eng_rst,
  output logic                  eng_ce,
  output logic                  busy
);

  state_e state_q, state_d;

  logic [1:0] win;
  logic       win_vld;
  chan_t      ptr_q, ptr_d;

  logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [1:0]            erst_q, erst_d;
  logic                  fin_err;

  logic [1:0]            gnt_q, gnt_d, done_q, done_d;
  logic                  done_err_q, done_err_d;
  logic [WCNT_WIDTH-1:0] done_words_q, done_words_d;
  chan_t                 eng_sel_q, eng_sel_d;
  logic [LZF_WIDTH-1:0]  eng_cnt_q, eng_cnt_d;
  logic                  eng_rst_q, eng_rst_d, eng_ce_q, eng_ce_d, busy_q, busy_d;

`ifdef ENCODE_SCHED_TMO_EN
  logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
  logic                 tmo_hit;

  always_comb begin
    tmo_d = '0;
    if (state_q == S_RUN && m_dst_putn) tmo_d = tmo_q + 1'b1;
  end
  assign tmo_hit = (state_q == S_RUN) && (tmo_d == '1);

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  encode_sched_rr u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win),
    .vld_o (win_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Abort takes priority over end-of-stream; end-of-stream over timeout.
  always_comb begin
    state_d = state_q;
    fin_err = 1'b0;
    unique case (state_q)
      S_IDLE: if (win_vld) state_d = S_ARB;
      S_ARB:  state_d = (eng_cnt_q == '0) ? S_FIN : S_ERST;
      S_ERST: begin
        if (abort) begin
          state_d = S_FIN;
          fin_err = 1'b1;
        end else if (erst_q == 2'(ERST_CYCLES - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_FIN;
          fin_err = 1'b1;
        end else if (!m_endn) begin
          state_d = S_FIN;
`ifdef ENCODE_SCHED_TMO_EN
        end else if (tmo_hit) begin
          state_d = S_FIN;
          fin_err = 1'b1;
`endif
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == S_ARB) wcnt_d = '0;
    else if (state_q == S_RUN && !m_dst_putn && wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
    erst_d       = (state_q == S_ERST) ? erst_q + 2'd1 : 2'd0;
    ptr_d        = (state_q == S_FIN) ? eng_sel_q : ptr_q;
    gnt_d        = (state_d == S_ARB) ? win : 2'b00;
    eng_sel_d    = (state_d == S_ARB) ? win[1] : eng_sel_q;
    eng_cnt_d    = (state_d == S_ARB) ? (win[1] ? len1 : len0) : eng_cnt_q;
    done_d       = (state_d == S_FIN) ? chan_onehot(eng_sel_q) : 2'b00;
    done_err_d   = (state_d == S_FIN) && fin_err;
    done_words_d = (state_d == S_FIN) ? wcnt_d : '0;
    eng_rst_d    = (state_d != S_RUN);
    eng_ce_d     = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= 1'b1;
      wcnt_q       <= '0;
      erst_q       <= 2'd0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      done_err_q   <= 1'b0;
      done_words_q <= '0;
      eng_sel_q    <= 1'b0;
      eng_cnt_q    <= '0;
      eng_rst_q    <= 1'b1;
      eng_ce_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      wcnt_q       <= wcnt_d;
      erst_q       <= erst_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      done_err_q   <= done_err_d;
      done_words_q <= done_words_d;
      eng_sel_q    <= eng_sel_d;
      eng_cnt_q    <= eng_cnt_d;
      eng_rst_q    <= eng_rst_d;
      eng_ce_q     <= eng_ce_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign done_err   = done_err_q;
  assign done_words = done_words_q;
  assign eng_sel    = eng_sel_q;
  assign eng_cnt    = eng_cnt_q;
  assign eng_rst    = eng_rst_q;
  assign eng_ce     = eng_ce_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_encode_sched.sv
// Directed bench for encode_sched: job table plus hand sequences for latency, hold-req, reset, abort.
module tb_encode_sched;

`ifdef ENCODE_SCHED_TMO_EN
  localparam int TMO_W = 4;
`else
  localparam int TMO_W = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [19:0] len0, len1;
  logic        abort, m_dst_putn, m_endn;
  logic [1:0]  gnt, done;
  logic        done_err, eng_sel, eng_rst, eng_ce, busy;
  logic [15:0] done_words;
  logic [19:0] eng_cnt;

  int checks = 0;
  int errors = 0;

  encode_sched #(.LZF_WIDTH(20), .WCNT_WIDTH(16), .TMO_WIDTH(TMO_W)) dut (
    .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1),
    .abort(abort), .m_dst_putn(m_dst_putn), .m_endn(m_endn),
    .gnt(gnt), .done(done), .done_err(done_err), .done_words(done_words),
    .eng_sel(eng_sel), .eng_cnt(eng_cnt), .eng_rst(eng_rst), .eng_ce(eng_ce),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [19:0] len0;
    logic [19:0] len1;
    int          nw;
    int          mode;   // 0 endn, 1 abort, 2 abort+endn+putn same cycle
    logic [1:0]  eg;     // expected gnt and done
    logic [15:0] ew;
    logic        ee;
    logic        ece;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 8 && g == 2'b00; i++) begin
      tick();
      if (gnt != 2'b00) g = gnt;
    end
  endtask

  task automatic wait_ce_or_done();
    for (int i = 0; i < 8 && !eng_ce && done == 2'b00; i++) tick();
  endtask

  task automatic run_job(input vec_t v, output logic [1:0] g, output logic [1:0] d,
                         output logic [15:0] w, output logic e, output logic ce_seen);
    req = v.req; len0 = v.len0; len1 = v.len1;
    d = 2'b00; w = '0; e = 1'b0; ce_seen = 1'b0;
    wait_gnt(g);
    req = 2'b00;
    wait_ce_or_done();
    if (eng_ce) begin
      ce_seen = 1'b1;
      for (int k = 0; k < v.nw; k++) begin
        m_dst_putn = 1'b0;
        tick();
      end
      m_dst_putn = 1'b1;
      case (v.mode)
        0: m_endn = 1'b0;
        1: abort = 1'b1;
        default: begin m_endn = 1'b0; abort = 1'b1; m_dst_putn = 1'b0; end
      endcase
      tick();
      m_endn = 1'b1; abort = 1'b0; m_dst_putn = 1'b1;
    end
    d = done; w = done_words; e = done_err;
    tick();
  endtask

  logic [1:0]  g, d;
  logic [15:0] w;
  logic        e, ce_seen, seen;
  logic [1:0]  expb[3];
  int          n;

  initial begin
    rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
    abort = 1'b0; m_dst_putn = 1'b1; m_endn = 1'b1;

    tbl[0] = '{2'b11, 20'd7,  20'd9, 2, 0, 2'b10, 16'd2, 1'b0, 1'b1};
    tbl[1] = '{2'b10, 20'd7,  20'd0, 0, 0, 2'b10, 16'd0, 1'b0, 1'b0};
    tbl[2] = '{2'b11, 20'd7,  20'd9, 3, 2, 2'b01, 16'd4, 1'b1, 1'b1};
    tbl[3] = '{2'b10, 20'd7,  20'd9, 0, 1, 2'b10, 16'd0, 1'b1, 1'b1};
    tbl[4] = '{2'b11, 20'd7,  20'd9, 1, 1, 2'b01, 16'd1, 1'b1, 1'b1};
    tbl[5] = '{2'b01, 20'd0,  20'd9, 0, 0, 2'b01, 16'd0, 1'b0, 1'b0};
    tbl[6] = '{2'b11, 20'd5,  20'd5, 6, 0, 2'b10, 16'd6, 1'b0, 1'b1};

    tick(); tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(done_err), 0);
    chk("rst_words", 32'(done_words), 0);
    chk("rst_sel", 32'(eng_sel), 0);
    chk("rst_cnt", 32'(eng_cnt), 0);
    chk("rst_eng_rst", 32'(eng_rst), 1);
    chk("rst_ce", 32'(eng_ce), 0);
    chk("rst_busy", 32'(busy), 0);

    // Cycle-exact first job on ch0: 5 words then end-of-stream.
    rst = 1'b0; req = 2'b01; len0 = 20'd100;
    tick();
    chk("a_gnt_c1", 32'(gnt), 32'h1);
    chk("a_busy", 32'(busy), 1);
    chk("a_cnt", 32'(eng_cnt), 100);
    chk("a_sel", 32'(eng_sel), 0);
    req = 2'b00;
    tick();
    chk("a_erst1", {eng_rst, eng_ce}, 32'b10);
    tick();
    chk("a_erst2", {eng_rst, eng_ce}, 32'b10);
    tick();
    chk("a_ce_c4", {eng_rst, eng_ce}, 32'b01);
    for (int k = 0; k < 5; k++) begin
      m_dst_putn = 1'b0;
      tick();
    end
    m_dst_putn = 1'b1; m_endn = 1'b0;
    tick();
    chk("a_done", 32'(done), 32'h1);
    chk("a_words", 32'(done_words), 5);
    chk("a_err", 32'(done_err), 0);
    chk("a_fin_eng", {eng_rst, eng_ce}, 32'b10);
    m_endn = 1'b1;
    tick();
    chk("a_idle_busy", 32'(busy), 0);
    chk("a_idle_done", 32'(done), 0);
    chk("a_cnt_hold", 32'(eng_cnt), 100);

    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i], g, d, w, e, ce_seen);
      chk($sformatf("t%0d_gnt", i), 32'(g), 32'(tbl[i].eg));
      chk($sformatf("t%0d_done", i), 32'(d), 32'(tbl[i].eg));
      chk($sformatf("t%0d_words", i), 32'(w), 32'(tbl[i].ew));
      chk($sformatf("t%0d_err", i), 32'(e), 32'(tbl[i].ee));
      chk($sformatf("t%0d_ce", i), 32'(ce_seen), 32'(tbl[i].ece));
    end

    // req=11 held continuously: grants alternate, each job done before next grant.
    expb[0] = 2'b01; expb[1] = 2'b10; expb[2] = 2'b01;
    req = 2'b11; len0 = 20'd3; len1 = 20'd3;
    for (int j = 0; j < 3; j++) begin
      wait_gnt(g);
      chk($sformatf("b%0d_gnt", j), 32'(g), 32'(expb[j]));
      if (j == 2) req = 2'b00;
      wait_ce_or_done();
      m_dst_putn = 1'b0;
      tick();
      m_dst_putn = 1'b1; m_endn = 1'b0;
      tick();
      m_endn = 1'b1;
      chk($sformatf("b%0d_done", j), 32'(done), 32'(expb[j]));
      chk($sformatf("b%0d_words", j), 32'(done_words), 1);
    end
    tick();

    // Reset mid-RUN: no done, engine back in reset, pointer back to 1.
    req = 2'b10; len1 = 20'd10;
    wait_gnt(g);
    chk("c_gnt", 32'(g), 32'h2);
    req = 2'b00;
    wait_ce_or_done();
    m_dst_putn = 1'b0;
    tick(); tick();
    m_dst_putn = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c_busy", 32'(busy), 0);
    chk("c_eng_rst", 32'(eng_rst), 1);
    chk("c_ce", 32'(eng_ce), 0);
    seen = (done != 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done != 2'b00) seen = 1'b1;
    end
    chk("c_no_done", 32'(seen), 0);
    req = 2'b11; len0 = 20'd2; len1 = 20'd2;
    wait_gnt(g);
    chk("c_ptr_reset_gnt", 32'(g), 32'h1);
    req = 2'b00;
    wait_ce_or_done();
    m_endn = 1'b0;
    tick();
    m_endn = 1'b1;
    chk("c_done", 32'(done), 32'h1);
    tick();

    // Abort during engine reset.
    req = 2'b10; len1 = 20'd4;
    wait_gnt(g);
    chk("d_gnt", 32'(g), 32'h2);
    req = 2'b00;
    tick();
    chk("d_in_erst", {eng_rst, eng_ce}, 32'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("d_done", 32'(done), 32'h2);
    chk("d_err", 32'(done_err), 1);
    chk("d_words", 32'(done_words), 0);
    chk("d_ce", 32'(eng_ce), 0);
    tick();

`ifdef ENCODE_SCHED_TMO_EN
    // Watchdog: no putn for 2^4-1 RUN cycles.
    req = 2'b01; len0 = 20'd8;
    wait_gnt(g);
    chk("e_gnt", 32'(g), 32'h1);
    req = 2'b00;
    wait_ce_or_done();
    n = 0;
    while (eng_ce && n < 40) begin
      n++;
      tick();
    end
    chk("e_run_cycles", 32'(n), 15);
    chk("e_done", 32'(done), 32'h1);
    chk("e_err", 32'(done_err), 1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
